dispatch_credit_arb: RTL and testbench

Credit-based round-robin arbiter that shares one execution-unit dispatch port among NUM_REQS issue lanes. It sits between the per-lane dispatch elastic buffers and a single shared execution unit (e.g. SFU). It grants at most one lane per cycle, registers the winner toward the unit, and never lets in-flight requests exceed the unit's input-queue credits.

---
 rtl/dispatch_credit_arb_pkg.sv | 17 +
 rtl/dispatch_rr_picker.sv | 31 +++
 rtl/dispatch_credit_arb.sv | 139 +++++++++++++
 tb/tb_dispatch_credit_arb.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_credit_arb_pkg.sv
// Shared types and helpers for the dispatch credit arbiter.
package dispatch_credit_arb_pkg;

  // Default width of the stall performance counter.
  localparam int unsigned PerfWDefault   = 44;
  localparam int unsigned NumReqsDefault = 4;
  localparam int unsigned SelWDefault    = $clog2(NumReqsDefault);

  // Lane index for the default lane count.
  typedef logic [SelWDefault-1:0] sel_t;

  // Width needed to hold a credit count in 0..credits.
  function automatic int unsigned credit_cnt_width(input int unsigned credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/dispatch_rr_picker.sv
// Combinational round-robin picker: first valid lane at or after ptr wins.
module dispatch_rr_picker #(
  parameter int unsigned NUM_REQS = 4,
  parameter int unsigned SELW     = $clog2(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] valid,
  input  logic [SELW-1:0]     ptr,
  output logic [NUM_REQS-1:0] grant,
  output logic [SELW-1:0]     idx,
  output logic                any_valid
);

  int unsigned lane;

  // Walk offsets from farthest to nearest so the lane closest to ptr is written last.
  always_comb begin
    grant     = '0;
    idx       = '0;
    lane      = 0;
    any_valid = |valid;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      lane = (32'(ptr) + 32'(i)) % NUM_REQS;
      if (valid[lane]) begin
        grant       = '0;
        grant[lane] = 1'b1;
        idx         = SELW'(lane);
      end
    end
  end

endmodule

// File: rtl/dispatch_credit_arb.sv
// Credit-based round-robin dispatch arbiter feeding one shared execution unit.
// Optional stall counter port perf_stalls is built when DISPATCH_ARB_PERF_EN is defined.
module dispatch_credit_arb
  import dispatch_credit_arb_pkg::*;
#(
  parameter int unsigned NUM_REQS = 4,
  parameter int unsigned DATAW    = 256,
  parameter int unsigned CREDITS  = 4,
  parameter int unsigned SELW     = $clog2(NUM_REQS),
  parameter int unsigned CNTW     = credit_cnt_width(CREDITS),
  parameter int unsigned PERF_W   = PerfWDefault
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQS-1:0]            req_valid,
  input  logic [NUM_REQS-1:0][DATAW-1:0] req_data,
  output logic [NUM_REQS-1:0]            req_ready,
  output logic                           out_valid,
  output logic [DATAW-1:0]               out_data,
  output logic [SELW-1:0]                out_sel,
  input  logic                           out_ready,
  input  logic                           credit_ret,
  output logic [CNTW-1:0]                credits_avail,
  output logic                           credit_err
`ifdef DISPATCH_ARB_PERF_EN
  ,
  output logic [PERF_W-1:0]              perf_stalls
`endif
);

  localparam logic [CNTW-1:0] CredMax = CNTW'(CREDITS);
  localparam logic [SELW-1:0] LastSel = SELW'(NUM_REQS - 1);

  logic [SELW-1:0]     ptr_q, ptr_d;
  logic [CNTW-1:0]     credits_q, credits_d;
  logic                err_q, err_d;
  logic                out_valid_q, out_valid_d;
  logic [DATAW-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0]     out_sel_q, out_sel_d;

  logic [NUM_REQS-1:0] pick_grant;
  logic [SELW-1:0]     pick_idx;
  logic                pick_any;
  logic                can_load;
  logic                grant_en;

  dispatch_rr_picker #(
    .NUM_REQS (NUM_REQS),
    .SELW     (SELW)
  ) u_picker (
    .valid     (req_valid),
    .ptr       (ptr_q),
    .grant     (pick_grant),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  // Grant only when the stage can take the winner and a credit is held; never during reset.
  always_comb begin
    can_load  = !out_valid_q || out_ready;
    grant_en  = reset && can_load && (credits_q != '0) && pick_any;
    req_ready = grant_en ? pick_grant : '0;
  end

  // Next-state for pointer, credits, sticky error and the output register.
  always_comb begin
    ptr_d       = ptr_q;
    credits_d   = credits_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;

    if (grant_en) begin
      ptr_d = (pick_idx == LastSel) ? '0 : pick_idx + 1'b1;
    end

    // A grant and a return in the same cycle cancel out.
    case ({grant_en, credit_ret})
      2'b10:   credits_d = credits_q - 1'b1;
      2'b01:   if (credits_q != CredMax) credits_d = credits_q + 1'b1;
      default: credits_d = credits_q;
    endcase

    // A return while already full means the unit over-returned.
    if (credit_ret && (credits_q == CredMax)) begin
      err_d = 1'b1;
    end

    if (can_load) begin
      out_valid_d = grant_en;
      if (grant_en) begin
        out_data_d = req_data[pick_idx];
        out_sel_d  = pick_idx;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q       <= '0;
      credits_q   <= CredMax;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      credits_q   <= credits_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_sel       = out_sel_q;
  assign credits_avail = credits_q;
  assign credit_err    = err_q;

`ifdef DISPATCH_ARB_PERF_EN
  logic [PERF_W-1:0] perf_q;

  // Count cycles where some lane wants dispatch but nothing is granted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_q <= '0;
    end else if (pick_any && !grant_en) begin
      perf_q <= perf_q + 1'b1;
    end
  end

  assign perf_stalls = perf_q;
`endif

endmodule

// File: tb/tb_dispatch_credit_arb.sv
// Self-checking bench for dispatch_credit_arb: cycle model plus directed literal checks.
module tb_dispatch_credit_arb;

  localparam int unsigned NUM_REQS = 4;
  localparam int unsigned DATAW    = 32;
  localparam int unsigned CREDITS  = 4;
  localparam int unsigned SELW     = $clog2(NUM_REQS);
  localparam int unsigned CNTW     = $clog2(CREDITS + 1);
  localparam int unsigned PERF_W   = 44;

  logic                           clk = 1'b0;
  logic                           reset;
  logic [NUM_REQS-1:0]            req_valid;
  logic [NUM_REQS-1:0][DATAW-1:0] req_data;
  logic [NUM_REQS-1:0]            req_ready;
  logic                           out_valid;
  logic [DATAW-1:0]               out_data;
  logic [SELW-1:0]                out_sel;
  logic                           out_ready;
  logic                           credit_ret;
  logic [CNTW-1:0]                credits_avail;
  logic                           credit_err;
`ifdef DISPATCH_ARB_PERF_EN
  logic [PERF_W-1:0]              perf_stalls;
`endif

  logic tie_ret;
  logic ret_pulse;
  assign credit_ret = tie_ret ? (out_valid & out_ready) : ret_pulse;

  dispatch_credit_arb #(
    .NUM_REQS (NUM_REQS),
    .DATAW    (DATAW),
    .CREDITS  (CREDITS),
    .SELW     (SELW),
    .CNTW     (CNTW),
    .PERF_W   (PERF_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_sel       (out_sel),
    .out_ready     (out_ready),
    .credit_ret    (credit_ret),
    .credits_avail (credits_avail),
    .credit_err    (credit_err)
`ifdef DISPATCH_ARB_PERF_EN
    ,
    .perf_stalls   (perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int stamp    = 0;
  int gnt_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int log_at(input int i);
    return (gnt_log.size() > i) ? gnt_log[i] : -1;
  endfunction

  // Inputs change only at posedge+1; data is re-stamped every cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    stamp++;
    for (int k = 0; k < NUM_REQS; k++) req_data[k] = 32'(stamp * 16 + k);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // ---------------- behavioural model ----------------
  int      m_cred;
  int      m_ptr;
  bit      m_ov;
  int      m_sel;
  int      m_data;
  bit      m_err;
  longint  m_perf;

  task automatic m_reset();
    m_cred = CREDITS;
    m_ptr  = 0;
    m_ov   = 0;
    m_sel  = 0;
    m_data = 0;
    m_err  = 0;
    m_perf = 0;
  endtask

  // Compare at negedge against the model, then advance the model at posedge.
  initial begin
    bit                             s_rst;
    bit                             s_ret;
    bit                             s_ordy;
    logic [NUM_REQS-1:0]            s_valid;
    logic [NUM_REQS-1:0][DATAW-1:0] s_data;
    int                             g;
    int                             lane;
    logic [NUM_REQS-1:0]            exp_ready;
    m_reset();
    forever begin
      @(negedge clk);
      s_rst   = reset;
      s_ret   = credit_ret;
      s_ordy  = out_ready;
      s_valid = req_valid;
      s_data  = req_data;
      if (!s_rst) m_reset();
      g = -1;
      if (s_rst && (!m_ov || s_ordy) && m_cred > 0) begin
        for (int i = 0; i < NUM_REQS; i++) begin
          lane = (m_ptr + i) % NUM_REQS;
          if (g < 0 && s_valid[lane]) g = lane;
        end
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      if (m_ov) begin
        chk("out_sel", 64'(out_sel), 64'(m_sel));
        chk("out_data", 64'(out_data), 64'(m_data));
      end
      chk("credits_avail", 64'(credits_avail), 64'(m_cred));
      chk("credit_err", 64'(credit_err), 64'(m_err));
`ifdef DISPATCH_ARB_PERF_EN
      chk("perf_stalls", 64'(perf_stalls), 64'(m_perf));
`endif
      for (int k = 0; k < NUM_REQS; k++) if (req_ready[k]) gnt_log.push_back(k);
      @(posedge clk);
      if (!s_rst) begin
        m_reset();
      end else begin
        if (!m_ov || s_ordy) begin
          m_ov = (g >= 0);
          if (g >= 0) begin
            m_sel  = g;
            m_data = int'(s_data[g]);
          end
        end
        if (s_ret && m_cred == CREDITS) m_err = 1;
        m_cred = m_cred - ((g >= 0) ? 1 : 0) + (s_ret ? 1 : 0);
        if (m_cred > CREDITS) m_cred = CREDITS;
        if (g >= 0) m_ptr = (g + 1) % NUM_REQS;
        if (s_valid != '0 && g < 0) m_perf++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int exp_d;
    logic [PERF_W-1:0] p0;
    reset     = 1'b0;
    req_valid = 4'hF;
    out_ready = 1'b1;
    tie_ret   = 1'b0;
    ret_pulse = 1'b0;
    for (int k = 0; k < NUM_REQS; k++) req_data[k] = 32'(k);
    tick();
    tick();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_credits", 64'(credits_avail), 64'd4);
    chk("rst_err", 64'(credit_err), 64'd0);

    // Continuous round robin with credits returned on each handshake.
    reset   = 1'b1;
    tie_ret = 1'b1;
    gnt_log.delete();
    repeat (8) tick();
    chk("rr_g0", 64'(log_at(0)), 64'd0);
    chk("rr_g1", 64'(log_at(1)), 64'd1);
    chk("rr_g2", 64'(log_at(2)), 64'd2);
    chk("rr_g3", 64'(log_at(3)), 64'd3);
    chk("rr_g4", 64'(log_at(4)), 64'd0);
    chk("rr_credits", 64'(credits_avail), 64'd3);

    // Drain, then exhaust credits with no returns.
    req_valid = '0;
    repeat (3) tick();
    tie_ret = 1'b0;
    req_valid = 4'hF;
    gnt_log.delete();
    repeat (8) tick();
    chk("exh_grants", 64'(gnt_log.size()), 64'd4);
    chk("exh_credits", 64'(credits_avail), 64'd0);
    chk("exh_ready", 64'(req_ready), 64'd0);
    gnt_log.delete();
    ret_pulse = 1'b1;
    tick();
    ret_pulse = 1'b0;
    tick();
    tick();
    chk("pulse_grants", 64'(gnt_log.size()), 64'd1);

    // Backpressure holding lane 2.
    out_ready = 1'b0;
    do_reset();
    req_valid = 4'b0100;
    exp_d = stamp * 16 + 2;
    tick();
    req_valid = 4'hF;
    gnt_log.delete();
    repeat (5) begin
      tick();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_sel", 64'(out_sel), 64'd2);
      chk("bp_data", 64'(out_data), 64'(exp_d));
    end
    chk("bp_nogrant", 64'(gnt_log.size()), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_next", 64'(log_at(0)), 64'd3);

    // Simultaneous grant and return, then over-return.
    do_reset();
    tick();
    tick();
    chk("cr_two", 64'(credits_avail), 64'd2);
    ret_pulse = 1'b1;
    tick();
    chk("cr_same", 64'(credits_avail), 64'd2);
    req_valid = '0;
    repeat (3) tick();
    ret_pulse = 1'b0;
    chk("cr_sat", 64'(credits_avail), 64'd4);
    chk("cr_err", 64'(credit_err), 64'd1);

    // Reset mid-stream.
    do_reset();
    chk("mr_err_clr", 64'(credit_err), 64'd0);
    req_valid = 4'hF;
    repeat (3) tick();
    chk("mr_pre_cred", 64'(credits_avail), 64'd1);
    chk("mr_pre_valid", 64'(out_valid), 64'd1);
    reset = 1'b0;
    #1;
    chk("mr_valid", 64'(out_valid), 64'd0);
    chk("mr_credits", 64'(credits_avail), 64'd4);
    chk("mr_ready", 64'(req_ready), 64'd0);
    tick();
    reset     = 1'b1;
    req_valid = 4'b1010;
    gnt_log.delete();
    tick();
    chk("mr_first", 64'(log_at(0)), 64'd1);

`ifdef DISPATCH_ARB_PERF_EN
    // Stall counting with credits exhausted.
    do_reset();
    req_valid = 4'hF;
    repeat (4) tick();
    req_valid = 4'b0010;
    p0 = perf_stalls;
    repeat (7) tick();
    chk("perf_inc", 64'(perf_stalls - p0), 64'd7);
`endif

    req_valid = '0;
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
